// File: rtl/config_pkg.sv
// config_pkg: core configuration record shared by the CVA6 blocks
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
    int unsigned NrCommitPorts;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, VLEN: 64, NrCommitPorts: 2};
endpackage

// File: rtl/riscv_pkg.sv
// riscv_pkg: landing-pad tracker state encoding, trap constants and exception record
package riscv_pkg;
  typedef enum logic [1:0] {NO_LP, LP_EXP, FAULT} lp_state_e;
  localparam logic [63:0] SW_CHECK      = 64'd18;
  localparam logic [63:0] LP_FAULT_TVAL = 64'd2;
  // valid sits in the LSB so a narrower exception_t keeps just the valid bit
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } lp_exception_t;
endpackage

// File: rtl/lpad_label_cmp.sv
// lpad_label_cmp: per-port landing-pad check (label zero is a wildcard); ZICFILP_LABEL_CHECK_EN enables labels
module lpad_label_cmp #(
  parameter int unsigned LPL_W = 20
) (
  input  logic             is_lpad,
  input  logic [LPL_W-1:0] lbl,
  input  logic [LPL_W-1:0] exp_lbl,
  output logic             pass
);
`ifdef ZICFILP_LABEL_CHECK_EN
  assign pass = is_lpad && (lbl == '0 || lbl == exp_lbl);
`else
  assign pass = is_lpad | (1'b0 & (|{lbl, exp_lbl}));
`endif
endmodule

// File: rtl/zicfilp_lp_tracker.sv
// zicfilp_lp_tracker: Zicfilp expected-landing-pad tracker at commit; labels checked when ZICFILP_LABEL_CHECK_EN is defined
module zicfilp_lp_tracker
  import riscv_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned LPL_W = 20,
  parameter type exception_t = logic
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            lp_en_i,
  input  logic                                            debug_mode_i,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]                commit_valid_i,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]                commit_is_ijmp_i,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]                commit_is_lpad_i,
  input  logic [CVA6Cfg.NrCommitPorts-1:0][LPL_W-1:0]     commit_lpl_i,
  input  logic [LPL_W-1:0]                                x7_lbl_i,
  input  logic                                            trap_i,
  input  logic                                            xret_i,
  input  logic                                            pelp_i,
  output logic                                            elp_o,
  output logic                                            pelp_o,
  output logic [CVA6Cfg.NrCommitPorts-1:0]                commit_kill_o,
  output exception_t                                      lp_exception_o,
  input  logic                                            exc_ack_i,
  output logic [15:0]                                     fault_cnt_o
);
  localparam int unsigned NP = CVA6Cfg.NrCommitPorts;
  lp_state_e state_q, state_d;
  logic [LPL_W-1:0] lbl_q, lbl_d;
  logic [NP-1:0][LPL_W-1:0] lbl_chk;
  logic [NP-1:0] pass, ijv;
  logic active, armed, bad, enter;
  lp_exception_t rec;
  assign ijv = commit_valid_i & commit_is_ijmp_i;
  // an older same-cycle ijmp arms with x7; if that port was killed, this one is killed too
  for (genvar g = 0; g < NP; g++) begin : g_cmp
    assign lbl_chk[g] = |(ijv & ((NP'(1) << g) - NP'(1))) ? x7_lbl_i : lbl_q;
    lpad_label_cmp #(.LPL_W(LPL_W)) u_cmp (
      .is_lpad(commit_is_lpad_i[g]),
      .lbl(commit_lpl_i[g]),
      .exp_lbl(lbl_chk[g]),
      .pass(pass[g])
    );
  end
  assign active = lp_en_i && !debug_mode_i && state_q != FAULT;
  always_comb begin
    armed = state_q == LP_EXP;
    bad = 1'b0;
    lbl_d = lbl_q;
    commit_kill_o = '0;
    for (int i = 0; i < NP; i++) begin
      if (active && commit_valid_i[i] && !bad) begin
        bad = armed && !pass[i];
        armed = !bad && commit_is_ijmp_i[i];
        lbl_d = armed ? x7_lbl_i : lbl_d;
      end
      commit_kill_o[i] = bad;
    end
    state_d = trap_i ? NO_LP :
              xret_i ? (pelp_i ? LP_EXP : NO_LP) :
              state_q == FAULT ? (exc_ack_i ? NO_LP : FAULT) :
              bad ? FAULT : armed ? LP_EXP : NO_LP;
    enter = state_d == FAULT && state_q != FAULT;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= NO_LP;
      lbl_q <= '0;
      pelp_o <= 1'b0;
      fault_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      lbl_q <= (xret_i && !trap_i) ? '0 : lbl_d;
      if (trap_i) pelp_o <= elp_o;
      fault_cnt_o <= fault_cnt_o + 16'(enter && fault_cnt_o != 16'hFFFF);
    end
  end
  assign elp_o = state_q != NO_LP;
  always_comb begin
    rec.valid = state_q == FAULT;
    rec.cause = rec.valid ? SW_CHECK : '0;
    rec.tval = rec.valid ? LP_FAULT_TVAL : '0;
  end
  assign lp_exception_o = exception_t'(rec);
endmodule

// File: tb/tb_zicfilp_lp_tracker.sv
// tb_zicfilp_lp_tracker: directed and randomized checks of the landing-pad tracker against a reference model
module tb_zicfilp_lp_tracker;
  import riscv_pkg::*;
  localparam bit LBL_EN =
`ifdef ZICFILP_LABEL_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0;
  logic rst, lp_en, dbg, trap, xret, pelp_i, ack;
  logic [1:0] cv, cij, clp;
  logic [1:0][19:0] lpl;
  logic [19:0] x7;
  logic elp, pelp_o;
  logic [1:0] kill;
  lp_exception_t exc;
  logic [15:0] cnt;
  int n_chk = 0, n_fail = 0;
  bit m_exp, m_fault, m_pelp;
  logic [19:0] m_lbl;
  int m_cnt;

  zicfilp_lp_tracker #(.LPL_W(20), .exception_t(lp_exception_t)) dut (
    .clk_i(clk), .rst_i(rst), .lp_en_i(lp_en), .debug_mode_i(dbg),
    .commit_valid_i(cv), .commit_is_ijmp_i(cij), .commit_is_lpad_i(clp),
    .commit_lpl_i(lpl), .x7_lbl_i(x7), .trap_i(trap), .xret_i(xret),
    .pelp_i(pelp_i), .elp_o(elp), .pelp_o(pelp_o), .commit_kill_o(kill),
    .lp_exception_o(exc), .exc_ack_i(ack), .fault_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    cv = '0; cij = '0; clp = '0; lpl = '0; trap = 0; xret = 0; pelp_i = 0; ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit lp_ok(bit lpad, logic [19:0] l, logic [19:0] e);
    return LBL_EN ? (lpad && (l == 0 || l == e)) : lpad;
  endfunction

  // the landing-pad rules applied to one commit group, one instruction at a time
  task automatic model_step(output logic [1:0] k);
    bit arm = m_exp;
    bit bad = 0;
    logic [19:0] l = m_lbl;
    k = '0;
    for (int i = 0; i < 2; i++) begin
      if (lp_en && !dbg && !m_fault && cv[i] && !bad) begin
        if (arm) begin
          if (lp_ok(clp[i], lpl[i], l)) arm = 0; else bad = 1;
        end
        if (!bad && cij[i]) begin arm = 1; l = x7; end
      end
      k[i] = bad;
    end
    if (trap) begin m_pelp = m_exp | m_fault; m_exp = 0; m_fault = 0; end
    else if (xret) begin m_exp = pelp_i; m_lbl = 0; m_fault = 0; end
    else if (m_fault) begin if (ack) m_fault = 0; end
    else if (bad) begin m_fault = 1; m_exp = 0; if (m_cnt < 65535) m_cnt++; end
    else begin m_exp = arm; m_lbl = l; end
  endtask

  task automatic test_reset();
    rst = 1; lp_en = 1; dbg = 0; x7 = '0; idle();
    step(); step();
    rst = 0;
    n_chk++; if (elp !== 1'b0) begin n_fail++; $display("FAIL reset_elp got=%b exp=0", elp); end
    n_chk++; if (pelp_o !== 1'b0) begin n_fail++; $display("FAIL reset_pelp got=%b exp=0", pelp_o); end
    n_chk++; if (exc.valid !== 1'b0) begin n_fail++; $display("FAIL reset_exc got=%b exp=0", exc.valid); end
    n_chk++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    n_chk++; if (kill !== 2'b00) begin n_fail++; $display("FAIL reset_kill got=%b exp=00", kill); end
  endtask

  task automatic test_basic();
    x7 = 20'h12345; cv = 2'b01; cij = 2'b01; #1;
    n_chk++; if (kill !== 2'b00) begin n_fail++; $display("FAIL basic_kill got=%b exp=00", kill); end
    step(); idle();
    n_chk++; if (elp !== 1'b1) begin n_fail++; $display("FAIL basic_arm got=%b exp=1", elp); end
    cv = 2'b01; clp = 2'b01; lpl[0] = 20'h12345;
    step(); idle();
    n_chk++; if (elp !== 1'b0) begin n_fail++; $display("FAIL basic_pass got=%b exp=0", elp); end
    n_chk++; if (exc.valid !== 1'b0) begin n_fail++; $display("FAIL basic_exc got=%b exp=0", exc.valid); end
  endtask

  task automatic test_same_cycle_fault();
    x7 = 20'h12345; cv = 2'b11; cij = 2'b01; clp = 2'b10; lpl[1] = 20'h00001; #1;
    n_chk++; if (kill !== (LBL_EN ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL sc_kill got=%b exp=%b", kill, LBL_EN ? 2'b10 : 2'b00); end
    n_chk++; if (exc.valid !== 1'b0) begin n_fail++; $display("FAIL sc_early_exc got=%b exp=0", exc.valid); end
    step(); idle();
    n_chk++; if (exc.valid !== LBL_EN) begin n_fail++; $display("FAIL sc_exc got=%b exp=%b", exc.valid, LBL_EN); end
    n_chk++; if (cnt !== 16'(LBL_EN)) begin n_fail++; $display("FAIL sc_cnt got=%0d exp=%0d", cnt, LBL_EN); end
    n_chk++; if (elp !== LBL_EN) begin n_fail++; $display("FAIL sc_elp got=%b exp=%b", elp, LBL_EN); end
    if (LBL_EN) begin
      n_chk++; if (exc.cause !== 64'd18 || exc.tval !== 64'd2) begin n_fail++; $display("FAIL sc_cause got=%0d/%0d exp=18/2", exc.cause, exc.tval); end
    end
    step();
    n_chk++; if (exc.valid !== LBL_EN) begin n_fail++; $display("FAIL sc_hold got=%b exp=%b", exc.valid, LBL_EN); end
    ack = 1; step(); idle();
    n_chk++; if (elp !== 1'b0 || exc.valid !== 1'b0) begin n_fail++; $display("FAIL sc_ack got=%b%b exp=00", elp, exc.valid); end
  endtask

  task automatic test_trap_xret();
    x7 = 20'h12345; cv = 2'b01; cij = 2'b01; step(); idle();
    trap = 1; step(); idle();
    n_chk++; if (pelp_o !== 1'b1) begin n_fail++; $display("FAIL trap_pelp got=%b exp=1", pelp_o); end
    n_chk++; if (elp !== 1'b0) begin n_fail++; $display("FAIL trap_elp got=%b exp=0", elp); end
    xret = 1; pelp_i = 1; step(); idle();
    n_chk++; if (elp !== 1'b1) begin n_fail++; $display("FAIL xret_elp got=%b exp=1", elp); end
    cv = 2'b01; clp = 2'b01; lpl[0] = 20'h7; #1;
    n_chk++; if (kill !== 2'b00) begin n_fail++; $display("FAIL xret_kill got=%b exp=00", kill); end
    step(); idle();
    n_chk++; if (elp !== 1'b0 || exc.valid !== 1'b0) begin n_fail++; $display("FAIL xret_pass got=%b%b exp=00", elp, exc.valid); end
  endtask

  task automatic test_debug();
    dbg = 1; cv = 2'b01; cij = 2'b01; step(); idle();
    n_chk++; if (elp !== 1'b0) begin n_fail++; $display("FAIL dbg_arm got=%b exp=0", elp); end
    cv = 2'b01; #1;
    n_chk++; if (kill !== 2'b00) begin n_fail++; $display("FAIL dbg_kill got=%b exp=00", kill); end
    step(); idle(); dbg = 0;
    n_chk++; if (exc.valid !== 1'b0) begin n_fail++; $display("FAIL dbg_exc got=%b exp=0", exc.valid); end
  endtask

  task automatic test_wildcard();
    x7 = 20'h5; cv = 2'b01; cij = 2'b01; step(); idle();
    cv = 2'b01; clp = 2'b01; lpl[0] = 20'h6; #1;
    n_chk++; if (kill !== (LBL_EN ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL wc_kill got=%b exp=%b", kill, LBL_EN ? 2'b11 : 2'b00); end
    step(); idle();
    n_chk++; if (exc.valid !== LBL_EN) begin n_fail++; $display("FAIL wc_exc got=%b exp=%b", exc.valid, LBL_EN); end
    ack = 1; step(); idle();
    cv = 2'b01; cij = 2'b01; step(); idle();
    cv = 2'b01; clp = 2'b01; lpl[0] = 20'h0; step(); idle();
    n_chk++; if (elp !== 1'b0 || exc.valid !== 1'b0) begin n_fail++; $display("FAIL wc_zero got=%b%b exp=00", elp, exc.valid); end
  endtask

  task automatic test_reset_in_fault();
    cv = 2'b01; cij = 2'b01; step(); idle();
    cv = 2'b01; #1;
    n_chk++; if (kill !== 2'b11) begin n_fail++; $display("FAIL rf_kill got=%b exp=11", kill); end
    step(); idle();
    n_chk++; if (exc.valid !== 1'b1) begin n_fail++; $display("FAIL rf_exc got=%b exp=1", exc.valid); end
    n_chk++; if (cnt !== (LBL_EN ? 16'd3 : 16'd1)) begin n_fail++; $display("FAIL rf_cnt got=%0d exp=%0d", cnt, LBL_EN ? 3 : 1); end
    rst = 1; step(); rst = 0;
    n_chk++; if (exc.valid !== 1'b0 || cnt !== 16'd0 || elp !== 1'b0) begin n_fail++; $display("FAIL rf_reset got=%b/%0d/%b exp=0/0/0", exc.valid, cnt, elp); end
  endtask

  task automatic test_random();
    logic [1:0] k;
    logic [19:0] pick [3] = '{20'h0, 20'h5, 20'h9};
    rst = 1; idle(); step(); rst = 0;
    m_exp = 0; m_fault = 0; m_pelp = 0; m_lbl = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      lp_en = ($urandom % 8) != 0;
      dbg = ($urandom % 10) == 0;
      trap = ($urandom % 20) == 0;
      xret = !trap && ($urandom % 20) == 0;
      pelp_i = 1'($urandom);
      ack = ($urandom % 3) == 0;
      cv = 2'($urandom); cij = 2'($urandom); clp = 2'($urandom);
      lpl[0] = pick[$urandom % 3]; lpl[1] = pick[$urandom % 3];
      x7 = pick[1 + $urandom % 2];
      #1;
      model_step(k);
      n_chk++; if (kill !== k) begin n_fail++; $display("FAIL rnd_kill c=%0d got=%b exp=%b", c, kill, k); end
      step();
      n_chk++; if (elp !== (m_exp | m_fault)) begin n_fail++; $display("FAIL rnd_elp c=%0d got=%b exp=%b", c, elp, m_exp | m_fault); end
      n_chk++; if (pelp_o !== m_pelp) begin n_fail++; $display("FAIL rnd_pelp c=%0d got=%b exp=%b", c, pelp_o, m_pelp); end
      n_chk++; if (exc.valid !== m_fault) begin n_fail++; $display("FAIL rnd_exc c=%0d got=%b exp=%b", c, exc.valid, m_fault); end
      n_chk++; if (cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, cnt, m_cnt); end
      if (m_fault) begin
        n_chk++; if (exc.cause !== 64'd18 || exc.tval !== 64'd2) begin n_fail++; $display("FAIL rnd_cause c=%0d got=%0d/%0d exp=18/2", c, exc.cause, exc.tval); end
      end
    end
    idle(); lp_en = 1; dbg = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle_fault();
    test_trap_xret();
    test_debug();
    test_wildcard();
    test_reset_in_fault();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/zicfilp_lp_tracker.md
ZICFILP_LP_TRACKER -- requirements
Module: zicfilp_lp_tracker

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration (XLEN, VLEN, NrCommitPorts).
REQ-002 SHALL have parameter LPL_W, default 20, landing-pad label width, legal 1..20.
REQ-003 SHALL have parameter exception_t, default logic, core exception record type.
REQ-004 SHALL have port clk_i  in  1  core clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port lp_en_i  in  1  xLPE enable for current privilege.
REQ-007 SHALL have port debug_mode_i  in  1  debug mode; arming and checking suppressed.
REQ-008 SHALL have port commit_valid_i  in  NrCommitPorts  per-port commit strobe, in program order, port 0 oldest.
REQ-009 SHALL have port commit_is_ijmp_i  in  NrCommitPorts  committed JALR with rs1 not in {x1,x5,x7}.
REQ-010 SHALL have port commit_is_lpad_i  in  NrCommitPorts  committed LPAD instruction.
REQ-011 SHALL have port commit_lpl_i  in  NrCommitPorts x LPL_W  LPAD immediate label per port.
REQ-012 SHALL have port x7_lbl_i  in  LPL_W  x7[31:32-LPL_W] at commit of the arming jump.
REQ-013 SHALL have port trap_i / xret_i  in  1 each  trap entry / xRET commit.
REQ-014 SHALL have port pelp_i  in  1  xPELP value restored on xRET.
REQ-015 SHALL have port elp_o  out  1  current ELP state (1 = LP_EXPECTED).
REQ-016 SHALL have port pelp_o  out  1  ELP captured at trap entry, for xPELP CSR write.
REQ-017 SHALL have port commit_kill_o  out  NrCommitPorts  suppress commit of faulting and younger ports.
REQ-018 SHALL have port lp_exception_o  out  exception_t  software-check exception record.
REQ-019 SHALL have port exc_ack_i  in  1  exception taken / pipeline flushed.
REQ-020 SHALL have port fault_cnt_o  out  16  saturating landing-pad fault counter.

Function
REQ-021 SHALL hold a state register with states NO_LP, LP_EXP, FAULT.
REQ-022 NO_LP -> LP_EXP when a committing port has commit_is_ijmp_i, lp_en_i=1, debug_mode_i=0, and no younger same-cycle port resolves it; label register captures x7_lbl_i.
REQ-023 While armed (registered or armed by an older port same cycle), the next valid port SHALL be checked: pass if commit_is_lpad_i and (label==0 or label==captured); pass -> NO_LP.
REQ-024 A failing check SHALL set commit_kill_o for that port and all younger ports that cycle, enter FAULT, increment fault_cnt_o (saturate at 0xFFFF).
REQ-025 In FAULT, lp_exception_o.valid SHALL be 1 with cause 18 (software check), tval 2; held until exc_ack_i, then -> NO_LP; latency fault-to-valid = 1 cycle.
REQ-026 trap_i SHALL register pelp_o <= elp_o and force NO_LP; trap_i has priority over commit and xret_i.
REQ-027 xret_i (no trap_i) SHALL load state from pelp_i (1 -> LP_EXP, label register cleared to 0, accepting any LPAD).
REQ-028 lp_en_i=0 or debug_mode_i=1 SHALL neither arm nor check; registered state is held.
REQ-029 An ijmp that itself passes a pending check SHALL re-arm in the same cycle.
REQ-030 elp_o SHALL be 1 in LP_EXP and FAULT.

Reset
REQ-031 On rst_i: state NO_LP, label 0, pelp_o 0, fault_cnt_o 0, lp_exception_o.valid 0, commit_kill_o 0; reset mid-FAULT drops the exception.

Configuration
REQ-032 Macro ZICFILP_LABEL_CHECK_EN defined: label compare per REQ-023; undefined: any LPAD passes, label register and x7_lbl_i unused, LPL_W ignored.

Structure
REQ-033 lp_state_e, cause/tval constants (SW_CHECK=18, LP_FAULT_TVAL=2) SHALL live in riscv_pkg.
REQ-034 One sub-module lpad_label_cmp (per-port pass/fail, label-zero wildcard) SHALL be instantiated NrCommitPorts times.

Verification
REQ-035 ijmp port0 (x7_lbl=0x12345), next cycle lpad lbl 0x12345 port0 -> elp_o 1 then 0, no exception.
REQ-036 ijmp port0, lpad lbl 0x00001 port1 same cycle -> commit_kill_o=2'b10, next cycle exception cause 18 tval 2, fault_cnt_o=1.
REQ-037 LP_EXP, trap_i -> pelp_o=1, elp_o=0; xret_i with pelp_i=1 then lpad lbl 0x7 -> pass.
REQ-038 debug_mode_i=1, ijmp then ADD -> no arming, no kill.
REQ-039 Macro undefined: ijmp lbl 0x5, lpad lbl 0x6 -> pass.
REQ-040 rst_i asserted in FAULT -> next cycle exception valid 0, fault_cnt_o 0.
